// File: rtl/uart_rx_if.sv
// uart_rx_if
//   Bundles the serial line and the received-byte outputs of uart_rx.
//   Signals:
//     rx            serial line into the receiver (idle high, 8N1, LSB first)
//     data          last correctly framed byte, held until the next good frame
//     data_valid    one-cycle pulse, data is valid in that cycle and afterwards
//     framing_error one-cycle pulse when a stop bit samples low
//     busy          receiver is somewhere inside a frame
//   Modports:
//     master  the receiver (drives data/flags, reads rx)
//     slave   the line driver / consumer (drives rx, reads data/flags)
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output data_valid,
        output framing_error,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  data_valid,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver with mid-bit sampling.
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset
//     bus        uart_rx_if.master: rx in; data, data_valid, framing_error, busy out
//     state_dbg  current FSM state for debug/observation
//   Output semantics: data_valid is a single-cycle qualifier with no back-pressure;
//   data is updated in the same cycle data_valid rises and holds until the next good
//   frame. framing_error is a single-cycle event and never coincides with data_valid.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_if.master      bus,
    output logic [2:0]     state_dbg
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  data_n;
    logic        valid_n, ferr_n;
    logic        rx_meta, rx_sync;

    // Two-flop synchronizer; reset to the idle-high level so that reset release
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            shift             <= '0;
            bus.data          <= '0;
            bus.data_valid    <= 1'b0;
            bus.framing_error <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            bit_idx           <= bit_idx_n;
            shift             <= shift_n;
            bus.data          <= data_n;
            bus.data_valid    <= valid_n;
            bus.framing_error <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = bus.data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_sync) state_n = START;
            end
            START: begin
                // Re-check the line at the middle of the start bit to reject glitches.
                if (cnt == HALF_CNT) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_sync;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_n = '0;
                    if (rx_sync) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not retrigger; wait for idle level.
                cnt_n = '0;
                if (rx_sync) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy  = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed and randomized checks of uart_rx with CLKS_PER_BIT = 16.
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int CLK_PER = 100;
    localparam int BIT_T   = CPB * CLK_PER;
    localparam int LAT     = 2 + (CPB - 1) / 2 + 1 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;

    uart_rx_if bif ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #(CLK_PER / 2) clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int busy_at_dv = 0;
    int busy_seen = 0;
    int last_dv_cyc = 0;
    int fall_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_data = 8'h00;

    always @(posedge clk) cyc = cyc + 1;

    // Output monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bif.data_valid) begin
                got_q.push_back(bif.data);
                dv_cnt      = dv_cnt + 1;
                last_dv_cyc = cyc;
                if (bif.busy) busy_at_dv = busy_at_dv + 1;
            end
            if (bif.framing_error) fe_cnt = fe_cnt + 1;
            if (bif.data_valid && bif.framing_error) both_cnt = both_cnt + 1;
            if (bif.busy) busy_seen = 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame with the given bit period; leaves rx at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_t);
        bif.rx   = 1'b0;
        fall_cyc = cyc;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            bif.rx = b[i];
            #(bit_t);
        end
        bif.rx = stop_bit;
        #(bit_t);
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4 * CPB * 10 && bif.busy; i++) @(negedge clk);
        check(tag, {31'b0, bif.busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check(tag, {24'b0, got_q.pop_front()}, {24'b0, exp_q.pop_front()});
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dv0, fe0, lat;
        logic [7:0] b;
        int bit_t;

        bif.rx = 1'b1;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_data",  {24'b0, bif.data}, 32'h00);
        check("rst_dv",    {31'b0, bif.data_valid}, 32'd0);
        check("rst_fe",    {31'b0, bif.framing_error}, 32'd0);
        check("rst_busy",  {31'b0, bif.busy}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single frame 0xA5
        #7;
        send_frame(8'hA5, 1'b1, BIT_T);
        wait_idle("a5_idle");
        lat = last_dv_cyc - fall_cyc;
        check("a5_latency", {31'b0, (lat >= LAT - 1 && lat <= LAT + 1)}, 32'd1);
        check("a5_fe", fe_cnt, 0);
        check("a5_busy_at_dv", busy_at_dv, 0);
        check("a5_data", {24'b0, bif.data}, {24'b0, exp_data});
        drain("a5");

        // Back-to-back frames
        @(negedge clk); #7;
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T);
        send_frame(8'h3C, 1'b1, BIT_T);
        wait_idle("b2b_idle");
        check("b2b_data", {24'b0, bif.data}, {24'b0, exp_data});
        drain("b2b");

        // Short glitch: 4 cycles low
        dv0 = dv_cnt; fe0 = fe_cnt; busy_seen = 0;
        @(negedge clk); #7;
        bif.rx = 1'b0;
        repeat (4) @(negedge clk);
        bif.rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_busy_seen", busy_seen, 1);
        check("glitch_busy_now", {31'b0, bif.busy}, 32'd0);
        check("glitch_dv", dv_cnt - dv0, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_data", {24'b0, bif.data}, {24'b0, exp_data});

        // Bad stop bit followed by a long break
        dv0 = dv_cnt; fe0 = fe_cnt;
        @(negedge clk); #7;
        send_frame(8'h81, 1'b0, BIT_T);
        #(50 * BIT_T);
        bif.rx = 1'b1;
        #(2 * BIT_T);
        check("break_fe_once", fe_cnt - fe0, 1);
        check("break_dv", dv_cnt - dv0, 0);
        check("break_data", {24'b0, bif.data}, {24'b0, exp_data});
        @(negedge clk); #7;
        send_frame(8'h42, 1'b1, BIT_T);
        wait_idle("after_break_idle");
        check("after_break_data", {24'b0, bif.data}, {24'b0, exp_data});
        drain("after_break");

        // Reset pulse during bit 4 of 0x55; the sender then leaves the line idle
        dv0 = dv_cnt; fe0 = fe_cnt;
        b = 8'h55;
        @(negedge clk); #7;
        bif.rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            bif.rx = b[i];
            #(BIT_T);
        end
        bif.rx = b[4];
        #(BIT_T / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_data = 8'h00;
        bif.rx = 1'b1;
        #(7 * BIT_T);
        check("rst_mid_dv", dv_cnt - dv0, 0);
        check("rst_mid_fe", fe_cnt - fe0, 0);
        check("rst_mid_data", {24'b0, bif.data}, {24'b0, exp_data});
        check("rst_mid_busy", {31'b0, bif.busy}, 32'd0);
        @(negedge clk); #7;
        send_frame(8'h55, 1'b1, BIT_T);
        wait_idle("rst_next_idle");
        check("rst_next_data", {24'b0, bif.data}, {24'b0, exp_data});
        drain("rst_next");

        // Random bytes with up to +/-2% bit-period skew and random short gaps
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            b     = 8'($urandom_range(0, 255));
            bit_t = BIT_T - 32 + int'($urandom_range(0, 64));
            send_frame(b, 1'b1, bit_t);
        end
        wait_idle("rand_idle");
        check("rand_data", {24'b0, bif.data}, {24'b0, exp_data});
        drain("rand");
        check("never_both", both_cnt, 0);
        check("busy_low_at_dv", busy_at_dv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 rx  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-005 data  output  8  last correctly framed byte; held until the next good frame.
REQ-006 data_valid  output  1  one-cycle pulse; data is valid in that cycle and afterwards.
REQ-007 framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 busy  output  1  high in every state except IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-010 Bit counter SHALL be 16 bits wide; bit index SHALL be 3 bits.
REQ-011 States SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-012 IDLE: counter held at 0. rx_sync==0 -> START, counter 0.
REQ-013 START: counter increments each cycle. When counter==(CLKS_PER_BIT-1)/2 (integer division), check rx_sync.
  - rx_sync==0 -> DATA, counter 0, bit index 0.
  - rx_sync==1 (glitch) -> IDLE, with no output pulse.
REQ-014 DATA: when counter==CLKS_PER_BIT-1, sample rx_sync into shift register bit[bit index] and reset counter to 0.
  - Bit index 7 -> STOP.
  - Otherwise bit index increments.
REQ-015 STOP: when counter==CLKS_PER_BIT-1, check rx_sync.
  - rx_sync==1 -> data<=shift register, data_valid=1 for exactly one cycle, -> IDLE.
  - rx_sync==0 -> framing_error=1 for exactly one cycle, data unchanged, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_sync==1, then -> IDLE. A line held low (break) SHALL produce exactly one framing_error.
REQ-017 data_valid and framing_error SHALL never assert in the same cycle, and SHALL be registered outputs.
REQ-018 A new start bit SHALL be accepted on the first IDLE cycle after data_valid, so back-to-back frames are received with no gap.
REQ-019 Latency: data_valid SHALL assert 2 + (CLKS_PER_BIT-1)/2 + 1 + 9*CLKS_PER_BIT cycles (±1) after the rx falling edge.
REQ-020 The data output SHALL be unaffected by glitches, framing errors and frames still in progress.

Reset
REQ-021 While rst=1, the block SHALL set:
  - state IDLE; counter, bit index and shift register to 0;
  - synchronizer flops to 1;
  - data=0x00, data_valid=0, framing_error=0, busy=0.
REQ-022 rst asserted mid-frame SHALL abort the frame with no pulse; reception resumes on the next falling edge after rst deasserts.

Verification (CLKS_PER_BIT=16)
REQ-023 Single frame 0xA5, good stop bit -> one data_valid pulse; data=0xA5; framing_error stays 0; busy drops to 0 in the same cycle.
REQ-024 Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three data_valid pulses in order, with data matching each frame.
REQ-025 rx low for 4 cycles, then high -> busy pulses, returns to IDLE; no data_valid, no framing_error; data unchanged.
REQ-026 Frame 0x81 with stop bit low, then rx held low for 50 bit times -> exactly one framing_error and data unchanged; a following good frame 0x42 yields data=0x42.
REQ-027 rst asserted for 1 cycle during bit 4 of frame 0x55 -> no pulse, data=0x00; next frame 0x55 -> data=0x55.
REQ-028 Random bytes with ±2% bit-period skew on rx -> every byte received correctly.
